// File: rtl/tri_regk_pipe_pkg.sv
// Shared helpers for the tri_regk_pipe elastic staging pipeline.
// Holds the occupancy update rule so that the top level stays free of
// counter arithmetic.
package tri_regk_pipe_pkg;

  // Next occupancy value.
  // A clear wins over everything else. A simultaneous accept and output
  // leaves the count unchanged.
  function automatic int unsigned occ_next(input int unsigned occ,
                                           input logic        inc,
                                           input logic        dec,
                                           input logic        clr);
    int unsigned nxt;
    nxt = occ;
    if (clr) begin
      nxt = 0;
    end else if (inc && !dec) begin
      nxt = occ + 1;
    end else if (dec && !inc) begin
      nxt = occ - 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tri_regk_pipe_stg.sv
// One stage of the elastic pipeline: a WIDTH-bit data register and its valid bit.
// Ports:
//   clk, rst     clock and asynchronous active-high reset (data -> INIT, val -> 0)
//   load         capture d and become valid
//   drain        content moves on this cycle; becomes invalid unless it also loads
//   clr          flush: drop the valid bit and keep the data
//   d / q        data in and data out
//   val          stage holds a live word
module tri_regk_pipe_stg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             val
);

  // The data register captures only on load, so words never move into bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= WIDTH'(INIT);
    end else if (load) begin
      q <= d;
    end
  end

  // Valid bit. A flush beats a load, and a load beats a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= 1'b0;
    end else if (clr) begin
      val <= 1'b0;
    end else if (load) begin
      val <= 1'b1;
    end else if (drain) begin
      val <= 1'b0;
    end
  end

endmodule

// File: rtl/tri_regk_pipe.sv
// Elastic, non-scannable staging pipeline: DEPTH stages of WIDTH bits each,
// with valid/ready backpressure, a flush input and an occupancy counter.
// LCB-style enables are act, force_t and thold_b. A low thold_b freezes everything.
// Ports:
//   nclk, sreset              clock and asynchronous active-high reset
//   vd, gd                    power and ground pins (no function)
//   act, force_t, thold_b     functional enable, forced enable, and hold (active low)
//   d_mode, sg, delay_lclkr,
//   mpw1_b, mpw2_b, scin      LCB compatibility pins (no function)
//   scout                     constant zero
//   din, din_val, din_rdy     input side of the handshake
//   dout, dout_val, dout_rdy  output side of the handshake (last stage)
//   flush                     invalidate all stages on the next edge
//   occupancy                 number of valid stages
module tri_regk_pipe
  import tri_regk_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned INIT   = 0,
  parameter int unsigned OCC_W  = 5
) (
  input  logic                         nclk,
  input  logic                         sreset,
  inout  wire                          vd,
  inout  wire                          gd,
  input  logic                         act,
  input  logic                         force_t,
  input  logic                         thold_b,
  input  logic                         d_mode,
  input  logic                         sg,
  input  logic                         delay_lclkr,
  input  logic                         mpw1_b,
  input  logic                         mpw2_b,
  input  logic [OFFSET:OFFSET+WIDTH-1] scin,
  output logic [OFFSET:OFFSET+WIDTH-1] scout,
  input  logic [OFFSET:OFFSET+WIDTH-1] din,
  input  logic                         din_val,
  output logic                         din_rdy,
  output logic [OFFSET:OFFSET+WIDTH-1] dout,
  output logic                         dout_val,
  input  logic                         dout_rdy,
  input  logic                         flush,
  output logic [OCC_W-1:0]             occupancy
);

  logic             en;
  logic             clr;
  logic             out_go;
  logic             accept;
  logic [DEPTH-1:0] val;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic [DEPTH-1:0] free;
  logic [WIDTH-1:0] data  [DEPTH];
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic             unused_pins;

  // Pins kept only for LCB port compatibility.
  assign unused_pins = ^{vd, gd, d_mode, sg, delay_lclkr, mpw1_b, mpw2_b, scin};
  assign scout       = '0;

  // Handshake and ready ripple. free[] is resolved from the output stage back
  // to the input stage, so a full pipe still moves one word per cycle.
  always_comb begin
    en     = (act | force_t) & thold_b;
    clr    = flush & thold_b;
    load   = '0;
    drain  = '0;
    free   = '0;
    out_go = en & val[DEPTH-1] & dout_rdy;

    drain[DEPTH-1] = out_go;
    free[DEPTH-1]  = ~val[DEPTH-1] | out_go;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      // No moves between stages during a flush, so data registers hold.
      load[i+1] = en & ~flush & val[i] & free[i+1];
      drain[i]  = load[i+1];
      free[i]   = ~val[i] | drain[i];
    end

    din_rdy = en & ~flush & free[0];
    accept  = din_val & din_rdy;
    load[0] = accept;
  end

  // Stage chain. Stage 0 takes din, and every later stage takes its predecessor.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    if (g == 0) begin : g_head
      assign stg_d[g] = din;
    end else begin : g_body
      assign stg_d[g] = data[g-1];
    end

    tri_regk_pipe_stg #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_stg (
      .clk   (nclk),
      .rst   (sreset),
      .load  (load[g]),
      .drain (drain[g]),
      .clr   (clr),
      .d     (stg_d[g]),
      .q     (data[g]),
      .val   (val[g])
    );
  end

  assign dout     = data[DEPTH-1];
  assign dout_val = val[DEPTH-1];

  // The occupancy counter follows the same accept, output and flush events as the valid bits.
  always_ff @(posedge nclk or posedge sreset) begin
    if (sreset) begin
      occupancy <= '0;
    end else begin
      occupancy <= OCC_W'(occ_next(32'(occupancy), accept, out_go, clr));
    end
  end

endmodule

// File: tb/tb_tri_regk_pipe.sv
// Scoreboard bench for tri_regk_pipe.
// The bench has two instances:
//   u_a   WIDTH=8, DEPTH=3, INIT=0xA5
//   u_b   WIDTH=8, DEPTH=1
// Drivers push each word they expect to be accepted into a queue. Monitors pop
// that queue and compare it with dout on every output handshake.
module tb_tri_regk_pipe;

  logic nclk = 1'b0;
  always #5 nclk = ~nclk;

  wire vdd = 1'b1;
  wire gnd = 1'b0;
  logic       tie0;
  logic [7:0] scin_z;

  // Instance A
  logic       rst_a, act_a, force_a, thold_a, flush_a, val_in_a, rdy_a;
  logic [7:0] din_a, dout_a, scout_a;
  logic       din_rdy_a, dout_val_a;
  logic [4:0] occ_a;

  // Instance B
  logic       rst_b, val_in_b, rdy_b;
  logic [7:0] din_b, dout_b, scout_b;
  logic       din_rdy_b, dout_val_b;
  logic [4:0] occ_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  tri_regk_pipe #(.WIDTH(8), .DEPTH(3), .OFFSET(0), .INIT(32'hA5), .OCC_W(5)) u_a (
    .nclk(nclk), .sreset(rst_a), .vd(vdd), .gd(gnd),
    .act(act_a), .force_t(force_a), .thold_b(thold_a),
    .d_mode(tie0), .sg(tie0), .delay_lclkr(tie0), .mpw1_b(tie0), .mpw2_b(tie0),
    .scin(scin_z), .scout(scout_a),
    .din(din_a), .din_val(val_in_a), .din_rdy(din_rdy_a),
    .dout(dout_a), .dout_val(dout_val_a), .dout_rdy(rdy_a),
    .flush(flush_a), .occupancy(occ_a)
  );

  tri_regk_pipe #(.WIDTH(8), .DEPTH(1), .OFFSET(0), .INIT(32'h0), .OCC_W(5)) u_b (
    .nclk(nclk), .sreset(rst_b), .vd(vdd), .gd(gnd),
    .act(1'b1), .force_t(1'b0), .thold_b(1'b1),
    .d_mode(tie0), .sg(tie0), .delay_lclkr(tie0), .mpw1_b(tie0), .mpw2_b(tie0),
    .scin(scin_z), .scout(scout_b),
    .din(din_b), .din_val(val_in_b), .din_rdy(din_rdy_b),
    .dout(dout_b), .dout_val(dout_val_b), .dout_rdy(rdy_b),
    .flush(1'b0), .occupancy(occ_b)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor A: an output handshake happens when the stage is valid, the consumer is ready and the pipe is enabled.
  always @(negedge nclk) begin
    if (!rst_a) begin
      if (dout_val_a && rdy_a && (act_a | force_a) && thold_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_a: got word %0h, expected none", dout_a);
        end else begin
          chk("mon_a dout", dout_a, qa.pop_front());
        end
      end
      if (flush_a && thold_a) qa.delete();
    end
  end

  // Monitor B: enable is tied on.
  always @(negedge nclk) begin
    if (!rst_b && dout_val_b && rdy_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_b: got word %0h, expected none", dout_b);
      end else begin
        chk("mon_b dout", dout_b, qb.pop_front());
      end
    end
  end

  // One cycle on A. Inputs change just after posedge, and checks run on the
  // negedge. An expected value of -1 means that check is skipped.
  task automatic drv_a(input logic v, input logic [7:0] d, input logic r,
                       input int e_rdy, input int e_occ, input int e_dval);
    val_in_a = v;
    din_a    = d;
    rdy_a    = r;
    @(negedge nclk);
    if (e_rdy >= 0)  chk("din_rdy_a", din_rdy_a, e_rdy);
    if (e_occ >= 0)  chk("occ_a", occ_a, e_occ);
    if (e_dval >= 0) chk("dout_val_a", dout_val_a, e_dval);
    chk("scout_a", scout_a, 0);
    if (v && e_rdy == 1) qa.push_back(d);
    @(posedge nclk);
    #1;
  endtask

  task automatic drv_b(input logic v, input logic [7:0] d, input logic r,
                       input int e_rdy, input int e_occ);
    val_in_b = v;
    din_b    = d;
    rdy_b    = r;
    @(negedge nclk);
    chk("din_rdy_b", din_rdy_b, e_rdy);
    chk("occ_b", occ_b, e_occ);
    chk("scout_b", scout_b, 0);
    if (v && e_rdy == 1) qb.push_back(d);
    @(posedge nclk);
    #1;
  endtask

  task automatic run_a();
    // Streaming: 16 back-to-back words. The first word reaches the output 3 cycles after it is accepted.
    for (int j = 0; j < 16; j++) begin
      drv_a(1'b1, 8'(j + 1), 1'b1, 1, (j < 3) ? j : 3, (j >= 3) ? 1 : 0);
    end
    for (int j = 0; j < 4; j++) begin
      drv_a(1'b0, 8'h00, 1'b1, 1, 3 - j, (j < 3) ? 1 : 0);
    end

    // Backpressure: the pipe fills while the consumer is stalled.
    drv_a(1'b1, 8'h11, 1'b0, 1, 0, 0);
    drv_a(1'b1, 8'h22, 1'b0, 1, 1, 0);
    drv_a(1'b1, 8'h33, 1'b0, 1, 2, 0);
    drv_a(1'b1, 8'h44, 1'b0, 0, 3, 1);
    drv_a(1'b1, 8'h44, 1'b1, 1, 3, 1);    // 0x11 leaves while 0x44 enters

    // Gating: with no enable, nothing moves.
    act_a = 1'b0;
    drv_a(1'b1, 8'h55, 1'b1, 0, 3, 1);
    chk("gate dout_a", dout_a, 8'h22);
    drv_a(1'b1, 8'h55, 1'b1, 0, 3, 1);
    chk("gate dout_a 2", dout_a, 8'h22);
    force_a = 1'b1;
    drv_a(1'b1, 8'h55, 1'b1, 1, 3, 1);    // 0x22 out, 0x55 in
    thold_a = 1'b0;
    flush_a = 1'b1;
    drv_a(1'b1, 8'h66, 1'b1, 0, 3, 1);    // frozen, so the flush is ignored
    chk("thold dout_a", dout_a, 8'h33);
    thold_a = 1'b1;
    flush_a = 1'b0;
    force_a = 1'b0;
    act_a   = 1'b1;
    drv_a(1'b0, 8'h00, 1'b1, 1, 3, 1);    // 0x33 out

    // Flush with occupancy 2: the output word is consumed and the input word is refused.
    flush_a = 1'b1;
    drv_a(1'b1, 8'h77, 1'b1, 0, 2, 1);    // 0x44 out
    flush_a = 1'b0;
    drv_a(1'b0, 8'h00, 1'b1, 1, 0, 0);
    chk("flush dout_a hold", dout_a, 8'h44);

    // Asynchronous reset with 2 words in flight.
    drv_a(1'b1, 8'h81, 1'b0, 1, 0, 0);
    drv_a(1'b1, 8'h82, 1'b0, 1, 1, 0);
    rst_a = 1'b1;
    #1;
    chk("rst dout_a", dout_a, 8'hA5);
    chk("rst dout_val_a", dout_val_a, 0);
    chk("rst occ_a", occ_a, 0);
    qa.delete();
    #1;
    rst_a = 1'b0;
    drv_a(1'b1, 8'h90, 1'b1, 1, 0, 0);
    drv_a(1'b0, 8'h00, 1'b1, 1, 1, 0);
    drv_a(1'b0, 8'h00, 1'b1, 1, 1, 0);
    drv_a(1'b0, 8'h00, 1'b1, 1, 1, 1);
    drv_a(1'b0, 8'h00, 1'b1, 1, 0, 0);
  endtask

  task automatic run_b();
    int acc = 0;
    // DEPTH=1: continuous input while dout_rdy alternates 0 and 1.
    for (int k = 0; k < 10; k++) begin
      logic r;
      int   e_rdy;
      r     = (k % 2 == 1);
      e_rdy = (k == 0 || r) ? 1 : 0;
      drv_b(1'b1, 8'(8'hB0 + acc), r, e_rdy, (k == 0) ? 0 : 1);
      if (e_rdy == 1) acc++;
    end
    drv_b(1'b0, 8'h00, 1'b1, 1, 1);
    drv_b(1'b0, 8'h00, 1'b1, 1, 0);
  endtask

  initial begin
    tie0 = 1'b0;  scin_z = 8'h00;
    rst_a = 1'b1; act_a = 1'b1; force_a = 1'b0; thold_a = 1'b1; flush_a = 1'b0;
    val_in_a = 1'b0; rdy_a = 1'b0; din_a = 8'h00;
    rst_b = 1'b1; val_in_b = 1'b0; rdy_b = 1'b0; din_b = 8'h00;
    #2;
    chk("reset dout_a", dout_a, 8'hA5);
    chk("reset dout_val_a", dout_val_a, 0);
    chk("reset occ_a", occ_a, 0);
    chk("reset din_rdy_a", din_rdy_a, 1);
    chk("reset dout_val_b", dout_val_b, 0);
    #9;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge nclk);
    #1;
    fork
      run_a();
      run_b();
    join
    chk("qa drained", qa.size(), 0);
    chk("qb drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
